// File: rtl/demux_1x4.sv
// Registered 1-to-4 demultiplexer: steers `a` onto one of four lanes selected by `sel`.
// Optional per-lane saturating transfer counters are compiled in when DEMUX_CNT_EN is defined.
module demux_1x4 #(
    parameter int DATA_W = 1,
    parameter int CNT_W  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic [DATA_W-1:0]     a,
    input  logic [1:0]            sel,
    output logic [4*DATA_W-1:0]   y,
    output logic [3:0]            y_vld
`ifdef DEMUX_CNT_EN
    ,
    input  logic                  cnt_clr,
    output logic [CNT_W-1:0]      cnt0,
    output logic [CNT_W-1:0]      cnt1,
    output logic [CNT_W-1:0]      cnt2,
    output logic [CNT_W-1:0]      cnt3
`endif
);

    if (DATA_W < 1 || CNT_W < 1) begin : g_bad_param
        $error("demux_1x4: DATA_W and CNT_W must be at least 1");
    end

    logic [4*DATA_W-1:0] y_nxt_s;
    logic [3:0]          vld_nxt_s;

    // Next-state routing: only the selected lane carries data, everything else is zero.
    always_comb begin
        y_nxt_s   = '0;
        vld_nxt_s = 4'b0000;
        if (enable) begin
            case (sel)
                2'd0: begin
                    y_nxt_s[0*DATA_W +: DATA_W] = a;
                    vld_nxt_s                   = 4'b0001;
                end
                2'd1: begin
                    y_nxt_s[1*DATA_W +: DATA_W] = a;
                    vld_nxt_s                   = 4'b0010;
                end
                2'd2: begin
                    y_nxt_s[2*DATA_W +: DATA_W] = a;
                    vld_nxt_s                   = 4'b0100;
                end
                2'd3: begin
                    y_nxt_s[3*DATA_W +: DATA_W] = a;
                    vld_nxt_s                   = 4'b1000;
                end
                default: begin
                    y_nxt_s   = '0;
                    vld_nxt_s = 4'b0000;
                end
            endcase
        end else begin
            y_nxt_s   = '0;
            vld_nxt_s = 4'b0000;
        end
    end

    // Output registers; every cycle fully rewrites both buses.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            y     <= '0;
            y_vld <= 4'b0000;
        end else begin
            y     <= y_nxt_s;
            y_vld <= vld_nxt_s;
        end
    end

`ifdef DEMUX_CNT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] cnt_r [4];

    // Per-lane transfer counters; clear wins over a same-edge increment, and counts stick at max.
    always_ff @(posedge clk) begin
        if (!rst_n || cnt_clr) begin
            for (int i = 0; i < 4; i++) begin
                cnt_r[i] <= '0;
            end
        end else if (enable && (cnt_r[sel] != CNT_MAX)) begin
            cnt_r[sel] <= cnt_r[sel] + CNT_W'(1);
        end else begin
            for (int i = 0; i < 4; i++) begin
                cnt_r[i] <= cnt_r[i];
            end
        end
    end

    assign cnt0 = cnt_r[0];
    assign cnt1 = cnt_r[1];
    assign cnt2 = cnt_r[2];
    assign cnt3 = cnt_r[3];
`endif

endmodule

// File: tb/tb_demux_1x4.sv
// Self-checking bench for demux_1x4: directed scenarios plus a randomized soak against a behavioural model.
// Counter checks are included when DEMUX_CNT_EN is defined.
module tb_demux_1x4;

    localparam int DATA_W = 1;
    localparam int CNT_W  = 2;
    localparam int CMAX   = (1 << CNT_W) - 1;

    logic                clk;
    logic                rst_n;
    logic                enable;
    logic [DATA_W-1:0]   a;
    logic [1:0]          sel;
    logic [4*DATA_W-1:0] y;
    logic [3:0]          y_vld;
    logic                cnt_clr;
`ifdef DEMUX_CNT_EN
    logic [CNT_W-1:0]    cnt0, cnt1, cnt2, cnt3;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    // Reference state: what the outputs must be after the most recent edge.
    logic [4*DATA_W-1:0] exp_y;
    logic [3:0]          exp_vld;
    int                  exp_cnt [4];

    demux_1x4 #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (enable),
        .a      (a),
        .sel    (sel),
        .y      (y),
        .y_vld  (y_vld)
`ifdef DEMUX_CNT_EN
        ,
        .cnt_clr(cnt_clr),
        .cnt0   (cnt0),
        .cnt1   (cnt1),
        .cnt2   (cnt2),
        .cnt3   (cnt3)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of inputs, advance the model, then compare all outputs just after the edge.
    task automatic step(input logic rn, input logic en, input logic [1:0] s,
                        input logic [DATA_W-1:0] d, input logic clr, input string tag);
        logic [4*DATA_W-1:0] lanes;
        rst_n   = rn;
        enable  = en;
        sel     = s;
        a       = d;
        cnt_clr = clr;
        @(posedge clk);
        #1;
        if (!rn) begin
            exp_y   = '0;
            exp_vld = 4'b0000;
            for (int i = 0; i < 4; i++) exp_cnt[i] = 0;
        end else begin
            lanes   = '0;
            lanes   = lanes | d;
            if (en) begin
                exp_y   = lanes << (int'(s) * DATA_W);
                exp_vld = 4'b0001 << s;
            end else begin
                exp_y   = '0;
                exp_vld = 4'b0000;
            end
            if (clr) begin
                for (int i = 0; i < 4; i++) exp_cnt[i] = 0;
            end else if (en && exp_cnt[s] < CMAX) begin
                exp_cnt[s] = exp_cnt[s] + 1;
            end
        end
        check({tag, ".y"}, 32'(y), 32'(exp_y));
        check({tag, ".y_vld"}, 32'(y_vld), 32'(exp_vld));
`ifdef DEMUX_CNT_EN
        check({tag, ".cnt0"}, 32'(cnt0), 32'(exp_cnt[0]));
        check({tag, ".cnt1"}, 32'(cnt1), 32'(exp_cnt[1]));
        check({tag, ".cnt2"}, 32'(cnt2), 32'(exp_cnt[2]));
        check({tag, ".cnt3"}, 32'(cnt3), 32'(exp_cnt[3]));
`endif
    endtask

    initial begin
        logic [1:0] rs;
        logic       rd;
        rst_n   = 1'b0;
        enable  = 1'b0;
        sel     = 2'd0;
        a       = 1'b0;
        cnt_clr = 1'b0;
        exp_y   = '0;
        exp_vld = 4'b0000;
        for (int i = 0; i < 4; i++) exp_cnt[i] = 0;

        // Reset dominates an active transfer request.
        step(1'b0, 1'b1, 2'd2, 1'b1, 1'b0, "reset0");
        step(1'b0, 1'b1, 2'd2, 1'b1, 1'b0, "reset1");
        check("reset_y_const", 32'(y), 32'h0);
        check("reset_vld_const", 32'(y_vld), 32'h0);

        step(1'b1, 1'b0, 2'd1, 1'b1, 1'b0, "disabled");
        check("disabled_vld_const", 32'(y_vld), 32'h0);

        // Lane sweep with one-cycle latency.
        for (int k = 0; k < 4; k++) begin
            step(1'b1, 1'b1, 2'(k), 1'b1, 1'b0, "sweep");
            check("sweep_y_const", 32'(y), 32'(4'b0001 << k));
            check("sweep_vld_const", 32'(y_vld), 32'(4'b0001 << k));
        end

        step(1'b1, 1'b1, 2'd3, 1'b0, 1'b0, "zero_data");
        check("zero_y_const", 32'(y), 32'h0);
        check("zero_vld_const", 32'(y_vld), 32'h8);

        // Random soak with a single-cycle reset pulse partway through.
        for (int i = 0; i < 40; i++) begin
            rs = 2'($urandom_range(0, 3));
            rd = 1'($urandom_range(0, 1));
            if (i == 20) begin
                step(1'b0, 1'b1, rs, rd, 1'b0, "soak_rst");
                check("soak_rst_vld_const", 32'(y_vld), 32'h0);
            end else begin
                step(1'b1, (i % 7) != 6, rs, rd, 1'b0, "soak");
            end
        end

        // Counter saturation and clear priority (routing still checked in the base build).
        step(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, "cnt_reset");
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b1, 2'd1, 1'($urandom_range(0, 1)), 1'b0, "cnt_lane1");
        end
`ifdef DEMUX_CNT_EN
        check("cnt1_saturated", 32'(cnt1), 32'd3);
        check("cnt0_idle", 32'(cnt0), 32'd0);
        check("cnt2_idle", 32'(cnt2), 32'd0);
        check("cnt3_idle", 32'(cnt3), 32'd0);
`endif
        step(1'b1, 1'b1, 2'd1, 1'b1, 1'b1, "cnt_clr");
`ifdef DEMUX_CNT_EN
        check("cnt1_cleared", 32'(cnt1), 32'd0);
`endif
        check("clr_route_vld", 32'(y_vld), 32'h2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
